ram_round_robin_arbiter: RTL and testbench
==========================================

Name: ram_round_robin_arbiter

Overview:
Shares the single RAM port among NREQ requesters, for example the I-fetch and D-miss/flush ports of two cores, using round-robin priority. A grant is held until the RAM reports ACCESS, ERROR, request withdrawal or timeout; the grant then rotates. The block sits between the coherence/cache controllers and the RAM model, and is the sole driver of the RAM request lines.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 255, max cycles a grant may wait for ACCESS before forced release (1..255)
IDXW, 2, width of owner index; must equal clog2(NREQ)

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  synchronous active-low reset, sampled on rising CLK
req  input  NREQ  per-requester request, level, held until rwait low
wen  input  NREQ  per-requester 1=write, 0=read; valid while req high
addr  input  NREQ*32  packed word addresses, requester i at [32*i+31:32*i]
store  input  NREQ*32  packed write data, same packing
rwait  output  NREQ  per-requester wait; low for exactly the completion cycle
rload  output  32  read data, equals ramload during owner's ACCESS cycle, else 0
ramstate  input  2  cpu_types_pkg ramstate_t (FREE, BUSY, ACCESS, ERROR)
ramload  input  32  RAM read data
ramaddr  output  32  RAM address
ramstore  output  32  RAM write data
ramREN  output  1  RAM read enable
ramWEN  output  1  RAM write enable
owner  output  IDXW  index of current grant holder (valid when busy)
busy  output  1  high in GRANT state
timeout_flag  output  1  sticky; set on any forced release

Behaviour:
- Reset (nRST low at posedge): state=IDLE, rr pointer=0, owner=0, timer=0, timeout_flag=0. Outputs during IDLE: rwait all 1, ram* all 0, rload=0, busy=0.
- States: IDLE, GRANT.
- IDLE: if any req is high, pick the first set bit scanning ptr, ptr+1, ... mod NREQ. Register owner and go to GRANT with timer=0. If no req is high, stay in IDLE.
- Latency: a req seen in IDLE at edge n drives ramREN/ramWEN from cycle n+1. Minimum completion is the cycle after grant if ramstate=ACCESS immediately.
- GRANT: ramaddr=addr[owner]. ramWEN=wen[owner]&req[owner]. ramREN=~wen[owner]&req[owner]. ramstore=store[owner] when writing, else 0. busy=1.
- GRANT with ramstate==ACCESS and req[owner]: rwait[owner]=0 combinationally; rload=ramload if reading. Next state is IDLE, ptr=owner+1 mod NREQ.
- GRANT with ramstate==ERROR: rwait stays 1 and the access is aborted. Next state is IDLE, ptr=owner+1. The requester competes again.
- GRANT with req[owner] low (withdrawn): drive no ram enables this cycle. Next state is IDLE, ptr=owner+1.
- Timer increments each GRANT cycle without ACCESS/ERROR. On the cycle timer==TIMEOUT-1 with no completion, force release: next state IDLE, ptr=owner+1, timeout_flag<=1. The flag is cleared only by reset.
- Priority within one GRANT cycle: ACCESS > ERROR > withdrawal > timeout.
- Each transaction includes one IDLE bubble, so a requester holding req continuously gets at most one access per rotation when others are requesting. A lone requester is re-granted after the one-cycle bubble.
- Non-owners always see rwait=1. rwait is never low outside GRANT.
- Reset mid-GRANT: the synchronous reset takes effect at the next edge, with enables dropping that cycle. Requesters must re-issue.
- Width rules: ptr and owner wrap mod NREQ. For non-power-of-2 NREQ, the increment compares against NREQ-1 explicitly.

Test Plan:
- Reset: hold nRST=0 for 2 cycles with req=4'b1111 → rwait=4'b1111, ramREN=ramWEN=0, busy=0; release → owner=0 granted next cycle.
- Single read: req[2]=1, wen=0, addr=32'h40, RAM returns ACCESS after 3 BUSY cycles with ramload=32'hDEADBEEF → ramREN=1 for 4 cycles, ramaddr=32'h40, rwait[2]=0 for 1 cycle with rload=32'hDEADBEEF, then IDLE.
- Round-robin fairness: req=4'b1111 continuously, RAM ACCESS every grant → owner sequence 0,1,2,3,0 with one IDLE cycle between each.
- Write path: req[1]=1, wen[1]=1, addr=32'h80, store=32'h12345678 → ramWEN=1, ramstore=32'h12345678, rload=0 on ACCESS.
- Timeout/error: TIMEOUT=4, RAM stuck BUSY → release after 4 GRANT cycles, timeout_flag=1, ptr advances. Separately, ERROR on a grant → rwait stays 1, next owner is granted.
- Withdrawal: req[0] dropped in the second GRANT cycle while req[3]=1 → enables drop in the same cycle, IDLE next, then owner=3 (ptr=1, first set at or after 1 is 3).

Source files
------------

// File: rtl/ram_round_robin_arbiter.sv
// Round-robin arbiter that shares one RAM port among NREQ requesters.
// A grant is held until the RAM completes, errors, the request is withdrawn,
// or the timeout expires. The priority pointer then moves past the owner.

package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module ram_round_robin_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned IDXW    = 2
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          wen,
  input  logic [NREQ*32-1:0]       addr,
  input  logic [NREQ*32-1:0]       store,
  output logic [NREQ-1:0]          rwait,
  output logic [31:0]              rload,
  input  cpu_types_pkg::ramstate_t ramstate,
  input  logic [31:0]              ramload,
  output logic [31:0]              ramaddr,
  output logic [31:0]              ramstore,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [IDXW-1:0]          owner,
  output logic                     busy,
  output logic                     timeout_flag
);
  import cpu_types_pkg::*;

  localparam int unsigned TW = 8;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, next_state;
  logic [IDXW-1:0] ptr, next_ptr, next_owner;
  logic [IDXW-1:0] pick, cand, owner_inc;
  logic [TW-1:0]   timer, next_timer;
  logic            found, set_timeout;
  logic            sel_req, sel_wen;
  logic [31:0]     sel_addr, sel_store;

  // Reduce an index in [0, 2*NREQ) back into [0, NREQ).
  function automatic logic [IDXW-1:0] wrap_idx(input int unsigned v);
    return (v >= NREQ) ? IDXW'(v - NREQ) : IDXW'(v);
  endfunction

  // First requester at or after ptr, scanning circularly.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = wrap_idx(32'(ptr) + k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Mux the current owner's request fields.
  always_comb begin
    sel_req   = 1'b0;
    sel_wen   = 1'b0;
    sel_addr  = '0;
    sel_store = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner == IDXW'(i)) begin
        sel_req   = req[i];
        sel_wen   = wen[i];
        sel_addr  = addr[32*i +: 32];
        sel_store = store[32*i +: 32];
      end
    end
  end

  // Explicit wrap so non-power-of-two NREQ rotates correctly.
  assign owner_inc = (owner == IDXW'(NREQ - 1)) ? '0 : owner + IDXW'(1);

  // Next-state and RAM-side outputs.
  always_comb begin
    next_state  = state;
    next_ptr    = ptr;
    next_owner  = owner;
    next_timer  = timer;
    set_timeout = 1'b0;
    rwait       = '1;
    rload       = '0;
    ramaddr     = '0;
    ramstore    = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          next_owner = pick;
          next_timer = '0;
          next_state = GRANT;
        end
      end
      GRANT: begin
        busy     = 1'b1;
        ramaddr  = sel_addr;
        ramWEN   = sel_wen & sel_req;
        ramREN   = ~sel_wen & sel_req;
        ramstore = (sel_wen & sel_req) ? sel_store : '0;
        if (ramstate == ACCESS && sel_req) begin
          rwait[owner] = 1'b0;
          rload        = sel_wen ? '0 : ramload;
          next_state   = IDLE;
          next_ptr     = owner_inc;
        end else if (ramstate == ERROR) begin
          next_state = IDLE;
          next_ptr   = owner_inc;
        end else if (!sel_req) begin
          next_state = IDLE;
          next_ptr   = owner_inc;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          next_state  = IDLE;
          next_ptr    = owner_inc;
          set_timeout = 1'b1;
        end else begin
          next_timer = timer + TW'(1);
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State, pointer, owner, timer and sticky timeout flag.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      timer        <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state  <= next_state;
      ptr    <= next_ptr;
      owner  <= next_owner;
      timer  <= next_timer;
      if (set_timeout) timeout_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_round_robin_arbiter.sv
// Directed bench for ram_round_robin_arbiter (NREQ=4, TIMEOUT=4).

module tb_ram_round_robin_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned NREQ = 4;

  logic              CLK = 1'b0;
  logic              nRST;
  logic [NREQ-1:0]   req, wen;
  logic [NREQ*32-1:0] addr, store;
  logic [NREQ-1:0]   rwait;
  logic [31:0]       rload, ramload, ramaddr, ramstore;
  ramstate_t         ramstate;
  logic              ramREN, ramWEN, busy, timeout_flag;
  logic [1:0]        owner;

  int checks = 0;
  int fails  = 0;

  ram_round_robin_arbiter #(.NREQ(4), .TIMEOUT(4), .IDXW(2)) dut (
    .CLK(CLK), .nRST(nRST), .req(req), .wen(wen), .addr(addr), .store(store),
    .rwait(rwait), .rload(rload), .ramstate(ramstate), .ramload(ramload),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
    .owner(owner), .busy(busy), .timeout_flag(timeout_flag)
  );

  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Synchronous reset for one edge, leaving the arbiter in IDLE with ptr=0.
  task automatic do_reset();
    nRST = 1'b0; req = '0; wen = '0; addr = '0; store = '0;
    ramstate = FREE; ramload = '0;
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; req = 4'b1111; wen = '0; addr = '0; store = '0;
    ramstate = BUSY; ramload = '0;
    addr[31:0] = 32'h0000_0010;
    for (int c = 0; c < 2; c++) begin
      tick(); #2;
      checks++; if (rwait !== 4'b1111) begin fails++; $display("FAIL reset_rwait: got %b want 1111", rwait); end
      checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin fails++; $display("FAIL reset_en: got ren=%b wen=%b want 0 0", ramREN, ramWEN); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (owner !== 2'd0 || timeout_flag !== 1'b0) begin fails++; $display("FAIL reset_regs: got owner=%0d tf=%b want 0 0", owner, timeout_flag); end
    end
    nRST = 1'b1;
    tick(); #2;
    checks++; if (busy !== 1'b1 || owner !== 2'd0) begin fails++; $display("FAIL reset_first_grant: got busy=%b owner=%0d want 1 0", busy, owner); end
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h10) begin fails++; $display("FAIL reset_first_ren: got ren=%b addr=%h want 1 00000010", ramREN, ramaddr); end
  endtask

  task automatic test_single_read();
    int ren_cycles;
    do_reset();
    req = 4'b0100; wen = '0; addr[32*2 +: 32] = 32'h40;
    ramstate = BUSY; ramload = 32'hDEADBEEF;
    #2;
    checks++; if (busy !== 1'b0 || ramREN !== 1'b0) begin fails++; $display("FAIL read_idle: got busy=%b ren=%b want 0 0", busy, ramREN); end
    ren_cycles = 0;
    for (int c = 0; c < 3; c++) begin
      tick(); #2;
      if (ramREN === 1'b1) ren_cycles++;
      checks++; if (rwait !== 4'b1111 || ramaddr !== 32'h40 || owner !== 2'd2) begin fails++; $display("FAIL read_busy%0d: got rwait=%b addr=%h owner=%0d want 1111 00000040 2", c, rwait, ramaddr, owner); end
    end
    tick(); ramstate = ACCESS; #2;
    if (ramREN === 1'b1) ren_cycles++;
    checks++; if (rwait !== 4'b1011) begin fails++; $display("FAIL read_rwait: got %b want 1011", rwait); end
    checks++; if (rload !== 32'hDEADBEEF || ramstore !== 32'h0) begin fails++; $display("FAIL read_rload: got rload=%h store=%h want deadbeef 00000000", rload, ramstore); end
    checks++; if (ren_cycles != 4) begin fails++; $display("FAIL read_ren_cycles: got %0d want 4", ren_cycles); end
    tick(); req = '0; #2;
    checks++; if (busy !== 1'b0 || rwait !== 4'b1111 || rload !== 32'h0) begin fails++; $display("FAIL read_after: got busy=%b rwait=%b rload=%h want 0 1111 0", busy, rwait, rload); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_owner;
    logic [3:0] exp_rwait;
    do_reset();
    req = 4'b1111; wen = '0; ramstate = ACCESS; ramload = 32'h1234;
    for (int k = 0; k < 5; k++) begin
      exp_owner = 2'(k % 4);
      exp_rwait = ~(4'b0001 << exp_owner);
      tick(); #2;
      checks++; if (busy !== 1'b1 || owner !== exp_owner || rwait !== exp_rwait) begin fails++; $display("FAIL rr_grant%0d: got busy=%b owner=%0d rwait=%b want 1 %0d %b", k, busy, owner, rwait, exp_owner, exp_rwait); end
      tick(); #2;
      checks++; if (busy !== 1'b0 || rwait !== 4'b1111) begin fails++; $display("FAIL rr_bubble%0d: got busy=%b rwait=%b want 0 1111", k, busy, rwait); end
    end
  endtask

  task automatic test_write();
    do_reset();
    req = 4'b0010; wen = 4'b0010; addr[32*1 +: 32] = 32'h80; store[32*1 +: 32] = 32'h12345678;
    ramstate = ACCESS; ramload = 32'hCAFEF00D;
    tick(); #2;
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin fails++; $display("FAIL write_en: got wen=%b ren=%b want 1 0", ramWEN, ramREN); end
    checks++; if (ramstore !== 32'h12345678 || ramaddr !== 32'h80) begin fails++; $display("FAIL write_data: got store=%h addr=%h want 12345678 00000080", ramstore, ramaddr); end
    checks++; if (rwait !== 4'b1101 || rload !== 32'h0) begin fails++; $display("FAIL write_done: got rwait=%b rload=%h want 1101 0", rwait, rload); end
    tick(); req = '0; #2;
    checks++; if (ramWEN !== 1'b0 || ramstore !== 32'h0) begin fails++; $display("FAIL write_idle: got wen=%b store=%h want 0 0", ramWEN, ramstore); end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0001; wen = '0; ramstate = BUSY;
    for (int c = 0; c < 4; c++) begin
      tick(); #2;
      checks++; if (busy !== 1'b1 || timeout_flag !== 1'b0) begin fails++; $display("FAIL to_hold%0d: got busy=%b tf=%b want 1 0", c, busy, timeout_flag); end
    end
    tick(); req = 4'b0011; #2;
    checks++; if (busy !== 1'b0 || timeout_flag !== 1'b1) begin fails++; $display("FAIL to_release: got busy=%b tf=%b want 0 1", busy, timeout_flag); end
    tick(); ramstate = ACCESS; #2;
    checks++; if (owner !== 2'd1 || timeout_flag !== 1'b1) begin fails++; $display("FAIL to_next: got owner=%0d tf=%b want 1 1", owner, timeout_flag); end
    tick(); req = '0;
  endtask

  task automatic test_error();
    do_reset();
    req = 4'b0101; wen = '0; ramstate = ERROR;
    tick(); #2;
    checks++; if (owner !== 2'd0 || rwait !== 4'b1111 || ramREN !== 1'b1) begin fails++; $display("FAIL err_grant: got owner=%0d rwait=%b ren=%b want 0 1111 1", owner, rwait, ramREN); end
    tick(); #2;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL err_idle: got busy=%b want 0", busy); end
    tick(); #2;
    checks++; if (owner !== 2'd2 || busy !== 1'b1 || timeout_flag !== 1'b0) begin fails++; $display("FAIL err_next: got owner=%0d busy=%b tf=%b want 2 1 0", owner, busy, timeout_flag); end
  endtask

  task automatic test_withdraw();
    do_reset();
    req = 4'b1001; wen = '0; ramstate = BUSY;
    tick(); #2;
    checks++; if (owner !== 2'd0 || ramREN !== 1'b1) begin fails++; $display("FAIL wd_grant: got owner=%0d ren=%b want 0 1", owner, ramREN); end
    tick(); req = 4'b1000; #2;
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || busy !== 1'b1 || rwait !== 4'b1111) begin fails++; $display("FAIL wd_drop: got ren=%b wen=%b busy=%b rwait=%b want 0 0 1 1111", ramREN, ramWEN, busy, rwait); end
    tick(); #2;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL wd_idle: got busy=%b want 0", busy); end
    tick(); #2;
    checks++; if (owner !== 2'd3 || busy !== 1'b1) begin fails++; $display("FAIL wd_next: got owner=%0d busy=%b want 3 1", owner, busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b0001; wen = '0; ramstate = ACCESS;
    for (int k = 0; k < 2; k++) begin
      tick(); #2;
      checks++; if (owner !== 2'd0 || rwait !== 4'b1110) begin fails++; $display("FAIL b2b_grant%0d: got owner=%0d rwait=%b want 0 1110", k, owner, rwait); end
      tick(); #2;
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_bubble%0d: got busy=%b want 0", k, busy); end
    end
    // reset in the middle of a grant drops enables after the next edge
    tick(); ramstate = BUSY; nRST = 1'b0; #2;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_pre_rst: got busy=%b want 1", busy); end
    tick(); #2;
    checks++; if (busy !== 1'b0 || ramREN !== 1'b0) begin fails++; $display("FAIL b2b_mid_rst: got busy=%b ren=%b want 0 0", busy, ramREN); end
    nRST = 1'b1; req = '0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_timeout();
    test_error();
    test_withdraw();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
